fusion_unit: RTL and testbench
==============================

# fusion_unit

Two-sensor diagonal-covariance fusion block for the six-state estimator. It takes two state estimates X1, X2 and the six diagonal covariance terms of each, P1 and P2. Per channel i it produces the inverse-variance-weighted fused state Xf_i = (P2·X1 + P1·X2)/(P1+P2) and the fused variance Pf_i = P1·P2/(P1+P2). It sits after the two per-sensor filters and feeds the fused state back to the predictor.

## Interface
Parameters: none. Widths are fixed by the shared package.
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input set valid; accepted when in_valid && in_ready on a rising edge
- in_ready  out  1  high only in IDLE
- P1_0, P1_6, P1_14, P1_21, P1_28, P1_36  in  16 signed  sensor-1 diagonal covariance, channels 0..5
- P2_0, P2_6, P2_14, P2_21, P2_28, P2_36  in  16 signed  sensor-2 diagonal covariance, channels 0..5
- X1_0..X1_5  in  16 signed  sensor-1 state, channels 0..5
- X2_0..X2_5  in  16 signed  sensor-2 state, channels 0..5
- X0f..X5f  out  16 signed  fused state, registered
- Pf1..Pf6  out  32 signed  fused variance, channels 0..5, registered
- out_valid  out  1  one-cycle pulse when all 12 results are updated

## Operation
- All 24 inputs are captured into internal registers at the accepting edge. Later input changes are ignored until the next acceptance.
- Channels are processed sequentially, 0 to 5.
- Per channel:
  - den = P1+P2, 17-bit signed.
  - numX = P2·X1 + P1·X2, 33-bit signed.
  - numP = P1·P2, 32-bit signed.
- Two dividers run concurrently: numX/den and numP/den.
- Division is signed, and the quotient truncates toward zero.
- The Xf quotient saturates to [-32768, 32767]. The Pf quotient always fits and is sign-extended to 32 bits.
- den == 0: Xf = (X1+X2)>>>1 (arithmetic shift, 17-bit sum) and Pf = 0. No division is performed, but the channel keeps its normal timing.
- Each output register is written when its channel finishes. Outputs hold their values between runs.
- FSM states:
  - IDLE goes to LOAD on acceptance.
  - LOAD (1 cycle: form products, den, and the operand magnitudes) goes to DIV.
  - DIV (33 cycles) writes the channel results. It then goes to LOAD for the next channel, or to IDLE after channel 5 while asserting out_valid.

## Timing
- Reset:
  - Effective at the edge where rst=1.
  - FSM goes to IDLE, all X*f and Pf* go to 0, out_valid goes to 0, channel counter goes to 0.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-run aborts the run. Partial results are cleared, not preserved.
- Channel timing: 34 cycles per channel (1 LOAD + 33 DIV).
- Channel k results are written at edge E+34(k+1), where E is the accepting edge.
- out_valid is high for exactly the one cycle after edge E+204. At that same edge in_ready returns high.
- Back-to-back runs: a new acceptance may occur on the edge immediately after out_valid asserts. Throughput is one set per 205 cycles.
- in_valid while busy is ignored; the producer holds it.
- rst and in_valid asserted together: reset wins and nothing is accepted.

## Structure
- Package fusion_pkg holds:
  - constants: DATA_W=16, COV_W=32, NUM_CH=6, DIV_ITER=33
  - enum: fsm_state_t {IDLE, LOAD, DIV}
- Sub-module fusion_div: sequential restoring divider on magnitudes.
  - Inputs: 33-bit dividend, 17-bit divisor.
  - One quotient bit per cycle, 33 cycles.
  - Sign fix-up at the end.
  - Instantiated twice, once for X and once for P.
- The top level holds the capture registers, channel mux, FSM, saturation, and output registers.

## Test plan
- Nominal, channels P1/P2/X1/X2 = 20/10/100/80, 30/15/110/90, 40/20/120/100, 50/25/130/110, 60/30/140/120, 70/35/150/130:
  - X0f..X5f = 86, 96, 106, 116, 126, 136.
  - Pf1..Pf6 = 6, 10, 13, 16, 20, 23.
  - out_valid pulses 205 cycles after acceptance.
- Truncation toward zero, P1=P2=1, X1=-3, X2=0: Xf = -1 and Pf = 0 (1/2 truncates to 0).
- Zero denominator, P1=5, P2=-5, X1=7, X2=-2: Xf = 2 and Pf = 0, with normal latency.
- Saturation, P1=1, P2=-2, X1=30000, X2=-30000: den = -1, raw quotient 90000, so Xf = 32767. Pf = 2.
- Protocol:
  - in_valid held during a run is not re-accepted and in_ready stays low.
  - A second set accepted on the edge right after out_valid produces correct results.
- Reset at cycle 100 of a run: outputs go to 0, no out_valid pulse, in_ready is high on the next cycle, and a fresh run completes correctly.

Source files
------------

// File: rtl/fusion_pkg.sv
// Shared widths, FSM encoding and helpers for the two-sensor covariance fusion block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fusion_pkg;

    localparam int DATA_W   = 16;            // state and covariance input width
    localparam int COV_W    = 32;            // fused variance output width
    localparam int NUM_CH   = 6;             // estimator channels
    localparam int DIV_ITER = 33;            // quotient bits produced per division
    localparam int DEN_W    = DATA_W + 1;    // P1+P2
    localparam int NUM_W    = 2 * DATA_W + 1;// P2*X1 + P1*X2
    localparam int CH_W     = 3;
    localparam int CNT_W    = 6;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    localparam logic signed [NUM_W-1:0] XF_MAX = 33'sd32767;
    localparam logic signed [NUM_W-1:0] XF_MIN = -33'sd32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2
    } fsm_state_t;

    // Sign-extend a 16-bit operand so products are formed at full width.
    function automatic logic signed [2*DATA_W-1:0] sext_prod(input logic signed [DATA_W-1:0] v);
        return {{DATA_W{v[DATA_W-1]}}, v};
    endfunction

    // Clamp a fused-state quotient into the 16-bit signed output range.
    function automatic logic signed [DATA_W-1:0] sat_xf(input logic signed [NUM_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > XF_MAX) begin
            r = 16'sh7fff;
        end else if (v < XF_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fusion_div.sv
// Signed restoring divider: 33-bit dividend / 17-bit divisor, quotient truncates toward zero.
// Latency: the start edge produces the first quotient bit; done is high after 33 edges total.
// Backpressure: none; a new start simply restarts the division.
//
// Ports: clk, rst (sync, active-high), start (load operands and do first step),
//        dividend/divisor (signed, sampled on start), quotient (signed, valid while done), done.
module fusion_div
    import fusion_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [NUM_W-1:0] dividend,
    input  logic signed [DEN_W-1:0] divisor,
    output logic signed [NUM_W-1:0] quotient,
    output logic                    done
);

    // Dividend magnitude shifts out of the top of q_q while quotient bits shift in at the bottom.
    logic [NUM_W-1:0] q_q;
    logic [DEN_W:0]   rem_q;
    logic [DEN_W-1:0] dvs_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NUM_W-1:0] dvd_mag;
    logic [DEN_W-1:0] dvs_mag;
    logic [NUM_W-1:0] q_in;
    logic [DEN_W:0]   rem_in;
    logic [DEN_W-1:0] dvs_in;
    logic [DEN_W:0]   rem_sh;
    logic [DEN_W+1:0] diff;
    logic             fits;
    logic             active;

    assign dvd_mag = dividend[NUM_W-1] ? $unsigned(-dividend) : $unsigned(dividend);
    assign dvs_mag = divisor[DEN_W-1]  ? $unsigned(-divisor)  : $unsigned(divisor);

    // On start the first step works directly on the incoming magnitudes, so the
    // 33 quotient bits land on the start edge plus the following 32 edges.
    always_comb begin
        q_in   = q_q;
        rem_in = rem_q;
        dvs_in = dvs_q;
        if (start) begin
            q_in   = dvd_mag;
            rem_in = '0;
            dvs_in = dvs_mag;
        end
        rem_sh = {rem_in[DEN_W-1:0], q_in[NUM_W-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs_in};
        fits   = ~diff[DEN_W+1];
    end

    assign active = (cnt_q != '0) && (cnt_q < CNT_W'(DIV_ITER));

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
        end else if (start || active) begin
            q_q   <= {q_in[NUM_W-2:0], fits};
            rem_q <= fits ? diff[DEN_W:0] : rem_sh;
            dvs_q <= dvs_in;
            cnt_q <= start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (start) begin
                neg_q <= dividend[NUM_W-1] ^ divisor[DEN_W-1];
            end
        end
    end

    assign done     = (cnt_q == CNT_W'(DIV_ITER));
    assign quotient = neg_q ? -$signed(q_q) : $signed(q_q);

endmodule

// File: rtl/fusion_unit.sv
// Six-channel inverse-variance fusion: Xf=(P2*X1+P1*X2)/(P1+P2), Pf=P1*P2/(P1+P2).
// Latency: channel k written 34*(k+1) edges after acceptance; out_valid after edge +204.
// Backpressure: in_ready high only in IDLE; in_valid while busy is ignored (producer holds).
//
// Ports: clk, rst (sync, active-high), in_valid/in_ready handshake,
//        P1_*/P2_* diagonal covariances, X1_*/X2_* states (captured on acceptance),
//        X0f..X5f fused states, Pf1..Pf6 fused variances, out_valid one-cycle completion pulse.
module fusion_unit
    import fusion_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] P1_0,
    input  logic signed [DATA_W-1:0] P1_6,
    input  logic signed [DATA_W-1:0] P1_14,
    input  logic signed [DATA_W-1:0] P1_21,
    input  logic signed [DATA_W-1:0] P1_28,
    input  logic signed [DATA_W-1:0] P1_36,
    input  logic signed [DATA_W-1:0] P2_0,
    input  logic signed [DATA_W-1:0] P2_6,
    input  logic signed [DATA_W-1:0] P2_14,
    input  logic signed [DATA_W-1:0] P2_21,
    input  logic signed [DATA_W-1:0] P2_28,
    input  logic signed [DATA_W-1:0] P2_36,
    input  logic signed [DATA_W-1:0] X1_0,
    input  logic signed [DATA_W-1:0] X1_1,
    input  logic signed [DATA_W-1:0] X1_2,
    input  logic signed [DATA_W-1:0] X1_3,
    input  logic signed [DATA_W-1:0] X1_4,
    input  logic signed [DATA_W-1:0] X1_5,
    input  logic signed [DATA_W-1:0] X2_0,
    input  logic signed [DATA_W-1:0] X2_1,
    input  logic signed [DATA_W-1:0] X2_2,
    input  logic signed [DATA_W-1:0] X2_3,
    input  logic signed [DATA_W-1:0] X2_4,
    input  logic signed [DATA_W-1:0] X2_5,
    output logic signed [DATA_W-1:0] X0f,
    output logic signed [DATA_W-1:0] X1f,
    output logic signed [DATA_W-1:0] X2f,
    output logic signed [DATA_W-1:0] X3f,
    output logic signed [DATA_W-1:0] X4f,
    output logic signed [DATA_W-1:0] X5f,
    output logic signed [COV_W-1:0]  Pf1,
    output logic signed [COV_W-1:0]  Pf2,
    output logic signed [COV_W-1:0]  Pf3,
    output logic signed [COV_W-1:0]  Pf4,
    output logic signed [COV_W-1:0]  Pf5,
    output logic signed [COV_W-1:0]  Pf6,
    output logic                     out_valid
);

    fsm_state_t state_q;
    logic [CH_W-1:0] ch_q;

    // Captured input set, held for the whole run.
    logic signed [DATA_W-1:0] p1_q [NUM_CH];
    logic signed [DATA_W-1:0] p2_q [NUM_CH];
    logic signed [DATA_W-1:0] x1_q [NUM_CH];
    logic signed [DATA_W-1:0] x2_q [NUM_CH];

    logic signed [DATA_W-1:0] xf_q [NUM_CH];
    logic signed [COV_W-1:0]  pf_q [NUM_CH];

    // Per-channel state kept from LOAD for the zero-denominator fallback.
    logic             den_zero_q;
    logic [DEN_W-1:0] xsum_q;

    logic signed [DATA_W-1:0]  p1_c, p2_c, x1_c, x2_c;
    logic signed [DEN_W-1:0]   den_c;
    logic [DEN_W-1:0]          xsum_c;
    logic signed [2*DATA_W-1:0] p2x1_c, p1x2_c, p1p2_c;
    logic signed [NUM_W-1:0]   numx_c, nump_c;
    logic signed [NUM_W-1:0]   qx, qp;
    logic                      done_x, done_p, div_done;
    logic                      div_start;
    logic                      unused_bits;

    // Channel mux over the captured set.
    assign p1_c = p1_q[ch_q];
    assign p2_c = p2_q[ch_q];
    assign x1_c = x1_q[ch_q];
    assign x2_c = x2_q[ch_q];

    assign den_c  = $signed({p1_c[DATA_W-1], p1_c}) + $signed({p2_c[DATA_W-1], p2_c});
    assign xsum_c = {x1_c[DATA_W-1], x1_c} + {x2_c[DATA_W-1], x2_c};

    assign p2x1_c = sext_prod(p2_c) * sext_prod(x1_c);
    assign p1x2_c = sext_prod(p1_c) * sext_prod(x2_c);
    assign p1p2_c = sext_prod(p1_c) * sext_prod(p2_c);
    assign numx_c = $signed({p2x1_c[2*DATA_W-1], p2x1_c}) + $signed({p1x2_c[2*DATA_W-1], p1x2_c});
    assign nump_c = $signed({p1p2_c[2*DATA_W-1], p1p2_c});

    // Dividers latch their operands at the end of LOAD.
    assign div_start = (state_q == LOAD);

    fusion_div u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (numx_c),
        .divisor  (den_c),
        .quotient (qx),
        .done     (done_x)
    );

    fusion_div u_div_p (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (nump_c),
        .divisor  (den_c),
        .quotient (qp),
        .done     (done_p)
    );

    assign div_done = done_x & done_p;

    // The Pf quotient magnitude never exceeds 2^30, so its top bit is redundant;
    // the shifted-out LSB of the zero-denominator sum is discarded by design.
    assign unused_bits = qp[NUM_W-1] ^ xsum_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            den_zero_q <= 1'b0;
            xsum_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                xf_q[i] <= '0;
                pf_q[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        p1_q[0] <= P1_0;  p1_q[1] <= P1_6;  p1_q[2] <= P1_14;
                        p1_q[3] <= P1_21; p1_q[4] <= P1_28; p1_q[5] <= P1_36;
                        p2_q[0] <= P2_0;  p2_q[1] <= P2_6;  p2_q[2] <= P2_14;
                        p2_q[3] <= P2_21; p2_q[4] <= P2_28; p2_q[5] <= P2_36;
                        x1_q[0] <= X1_0;  x1_q[1] <= X1_1;  x1_q[2] <= X1_2;
                        x1_q[3] <= X1_3;  x1_q[4] <= X1_4;  x1_q[5] <= X1_5;
                        x2_q[0] <= X2_0;  x2_q[1] <= X2_1;  x2_q[2] <= X2_2;
                        x2_q[3] <= X2_3;  x2_q[4] <= X2_4;  x2_q[5] <= X2_5;
                        ch_q     <= '0;
                        in_ready <= 1'b0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    den_zero_q <= (den_c == '0);
                    xsum_q     <= xsum_c;
                    state_q    <= DIV;
                end
                DIV: begin
                    if (div_done) begin
                        if (den_zero_q) begin
                            // Arithmetic halving of the 17-bit sum; always fits 16 bits.
                            xf_q[ch_q] <= $signed(xsum_q[DEN_W-1:1]);
                            pf_q[ch_q] <= '0;
                        end else begin
                            xf_q[ch_q] <= sat_xf(qx);
                            pf_q[ch_q] <= qp[COV_W-1:0];
                        end
                        if (ch_q == CH_LAST) begin
                            ch_q      <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            ch_q    <= ch_q + CH_W'(1);
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign X0f = xf_q[0];
    assign X1f = xf_q[1];
    assign X2f = xf_q[2];
    assign X3f = xf_q[3];
    assign X4f = xf_q[4];
    assign X5f = xf_q[5];
    assign Pf1 = pf_q[0];
    assign Pf2 = pf_q[1];
    assign Pf3 = pf_q[2];
    assign Pf4 = pf_q[3];
    assign Pf5 = pf_q[4];
    assign Pf6 = pf_q[5];

endmodule

// File: tb/tb_fusion_unit.sv
// Bench for fusion_unit: directed input sets, a cycle-level reference model and literal checks.
// Latency: n/a.
// Backpressure: holds in_valid during a run to show it is ignored while busy.
module tb_fusion_unit;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic out_valid;

    logic signed [15:0] p1_i [6];
    logic signed [15:0] p2_i [6];
    logic signed [15:0] x1_i [6];
    logic signed [15:0] x2_i [6];
    logic signed [15:0] xf_o [6];
    logic signed [31:0] pf_o [6];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fusion_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .P1_0(p1_i[0]), .P1_6(p1_i[1]), .P1_14(p1_i[2]), .P1_21(p1_i[3]), .P1_28(p1_i[4]), .P1_36(p1_i[5]),
        .P2_0(p2_i[0]), .P2_6(p2_i[1]), .P2_14(p2_i[2]), .P2_21(p2_i[3]), .P2_28(p2_i[4]), .P2_36(p2_i[5]),
        .X1_0(x1_i[0]), .X1_1(x1_i[1]), .X1_2(x1_i[2]), .X1_3(x1_i[3]), .X1_4(x1_i[4]), .X1_5(x1_i[5]),
        .X2_0(x2_i[0]), .X2_1(x2_i[1]), .X2_2(x2_i[2]), .X2_3(x2_i[3]), .X2_4(x2_i[4]), .X2_5(x2_i[5]),
        .X0f(xf_o[0]), .X1f(xf_o[1]), .X2f(xf_o[2]), .X3f(xf_o[3]), .X4f(xf_o[4]), .X5f(xf_o[5]),
        .Pf1(pf_o[0]), .Pf2(pf_o[1]), .Pf3(pf_o[2]), .Pf4(pf_o[3]), .Pf5(pf_o[4]), .Pf6(pf_o[5]),
        .out_valid(out_valid)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Fusion of one channel straight from the formulas, in 64-bit arithmetic.
    function automatic void fuse(input longint p1, input longint p2, input longint x1, input longint x2,
                                 output longint xf, output longint pf);
        longint den;
        den = p1 + p2;
        if (den == 0) begin
            xf = (x1 + x2) >>> 1;
            pf = 0;
        end else begin
            xf = (p2 * x1 + p1 * x2) / den;
            if (xf > 32767) xf = 32767;
            else if (xf < -32768) xf = -32768;
            pf = (p1 * p2) / den;
        end
    endfunction

    longint cap_p1 [6], cap_p2 [6], cap_x1 [6], cap_x2 [6];
    longint exp_xf [6], exp_pf [6];
    bit     exp_ov, exp_rdy, busy;
    int     t_run;

    // Channel k completes 34*(k+1) edges after acceptance; the run ends with channel 5.
    always @(posedge clk) begin
        longint xf, pf;
        int k;
        exp_ov = 1'b0;
        if (rst) begin
            busy    = 1'b0;
            exp_rdy = 1'b1;
            for (int i = 0; i < 6; i++) begin
                exp_xf[i] = 0;
                exp_pf[i] = 0;
            end
        end else if (!busy) begin
            if (in_valid) begin
                busy    = 1'b1;
                exp_rdy = 1'b0;
                t_run   = 0;
                for (int i = 0; i < 6; i++) begin
                    cap_p1[i] = p1_i[i];
                    cap_p2[i] = p2_i[i];
                    cap_x1[i] = x1_i[i];
                    cap_x2[i] = x2_i[i];
                end
            end
        end else begin
            t_run++;
            if (t_run % 34 == 0) begin
                k = t_run / 34 - 1;
                fuse(cap_p1[k], cap_p2[k], cap_x1[k], cap_x2[k], xf, pf);
                exp_xf[k] = xf;
                exp_pf[k] = pf;
                if (k == 5) begin
                    busy    = 1'b0;
                    exp_ov  = 1'b1;
                    exp_rdy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, exp_ov);
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("xf%0d", i), xf_o[i], exp_xf[i]);
                chk($sformatf("pf%0d", i), pf_o[i], exp_pf[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int nom_pf [6] = '{6, 10, 13, 16, 20, 23};

    task automatic set_ch(input int i, input int p1, input int p2, input int x1, input int x2);
        p1_i[i] = 16'(p1);
        p2_i[i] = 16'(p2);
        x1_i[i] = 16'(x1);
        x2_i[i] = 16'(x2);
    endtask

    task automatic load_nominal();
        for (int i = 0; i < 6; i++) set_ch(i, 20 + 10 * i, 10 + 5 * i, 100 + 10 * i, 80 + 10 * i);
    endtask

    task automatic check_nominal(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_xf%0d", tag, i), xf_o[i], 86 + 10 * i);
            chk($sformatf("%s_pf%0d", tag, i), pf_o[i], nom_pf[i]);
        end
    endtask

    // Counts negedges until out_valid is seen or the budget runs out.
    task automatic wait_ov(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < lim);
    endtask

    initial begin
        int n, pulses;
        rst      = 1'b1;
        in_valid = 1'b1;      // reset must win over a simultaneous request
        load_nominal();
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_xf0", xf_o[0], 0);
        chk("rst_pf6", pf_o[5], 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_ov", out_valid, 0);

        // Nominal set, in_valid held for the whole run.
        @(negedge clk);
        load_nominal();
        in_valid = 1'b1;
        wait_ov(300, n);
        chk("nominal_latency", n, 205);
        check_nominal("nom");

        // Corner set accepted on the edge right after out_valid.
        set_ch(0, 1, 1, -3, 0);
        set_ch(1, 5, -5, 7, -2);
        set_ch(2, 1, -2, 30000, -30000);
        set_ch(3, 1, -2, -30000, 30000);
        set_ch(4, -3, 7, -100, 50);
        set_ch(5, 32767, 32767, -32768, 32767);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_ready_low", in_ready, 0);
        wait_ov(300, n);
        chk("b2b_latency", n + 1, 205);
        chk("trunc_xf", xf_o[0], -1);
        chk("trunc_pf", pf_o[0], 0);
        chk("den0_xf", xf_o[1], 2);
        chk("den0_pf", pf_o[1], 0);
        chk("satpos_xf", xf_o[2], 32767);
        chk("satpos_pf", pf_o[2], 2);
        chk("satneg_xf", xf_o[3], -32768);
        chk("satneg_pf", pf_o[3], 2);
        chk("neg_xf", xf_o[4], -212);
        chk("neg_pf", pf_o[4], -5);
        chk("big_xf", xf_o[5], 0);
        chk("big_pf", pf_o[5], 16383);

        // Reset 100 cycles into a run.
        @(negedge clk);
        load_nominal();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_xf0", xf_o[0], 0);
        chk("midrst_pf2", pf_o[1], 0);
        chk("midrst_ready", in_ready, 1);
        pulses = 0;
        repeat (250) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        chk("midrst_no_ov", pulses, 0);

        // Fresh run after the abort.
        load_nominal();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(300, n);
        chk("fresh_latency", n + 1, 205);
        check_nominal("fresh");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
